// File: rtl/rd_dest_pipe.sv
// rd_dest_pipe: destination-register select plus a DEPTH-stage writeback pipe
// carrying (valid, rd), with stall/flush control and RAW hazard detection for
// two source indices against every in-flight entry.
// Optional feature macro: ZERO_REG_FILTER_EN (r0 treated as hardwired zero).
module rd_dest_pipe #(
  parameter int IW     = 32,
  parameter int RW     = 5,
  parameter int DEPTH  = 3,
  parameter int F0_LSB = 18,
  parameter int F1_LSB = 13,
  parameter int F2_LSB = 4,
  parameter int F3_LSB = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IW-1:0]                instr,
  input  logic [1:0]                   rd_orig,
  input  logic                         in_valid,
  input  logic                         wr_en_in,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [RW-1:0]                rs_a,
  input  logic [RW-1:0]                rs_b,
  output logic [RW-1:0]                rd_select,
  output logic [RW-1:0]                wb_rd,
  output logic                         wb_valid,
  output logic                         hazard_a,
  output logic                         hazard_b,
  output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [RW-1:0]    rd_q [DEPTH];
  logic [RW-1:0]    rd_d [DEPTH];
  logic             cap_v;

  // Instruction bits outside the four rd fields are intentionally ignored.
  logic unused_instr;
  assign unused_instr = ^instr;

  // Select the rd field according to its origin code; every code is decoded.
  always_comb begin
    case (rd_orig)
      2'b00:   rd_select = instr[F0_LSB +: RW];
      2'b01:   rd_select = instr[F1_LSB +: RW];
      2'b10:   rd_select = instr[F2_LSB +: RW];
      default: rd_select = instr[F3_LSB +: RW];
    endcase
  end

`ifdef ZERO_REG_FILTER_EN
  assign cap_v = in_valid & wr_en_in & (rd_select != '0);
`else
  assign cap_v = in_valid & wr_en_in;
`endif

  // Next pipe state: flush beats stall beats advance (reset handled in the register).
  always_comb begin
    v_d  = v_q;
    rd_d = rd_q;
    if (flush) begin
      v_d = '0;
    end else if (!stall) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        v_d[k]  = v_q[k-1];
        rd_d[k] = rd_q[k-1];
      end
      v_d[0]  = cap_v;
      rd_d[0] = rd_select;
    end
  end

  // Pipe registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) rd_q[k] <= '0;
    end else begin
      v_q  <= v_d;
      rd_q <= rd_d;
    end
  end

  assign wb_rd    = rd_q[DEPTH-1];
  assign wb_valid = v_q[DEPTH-1];

  // Hazard compare of both sources against all valid in-flight entries.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (v_q[k] && (rd_q[k] == rs_a)) hazard_a = 1'b1;
      if (v_q[k] && (rd_q[k] == rs_b)) hazard_b = 1'b1;
    end
`ifdef ZERO_REG_FILTER_EN
    if (rs_a == '0) hazard_a = 1'b0;
    if (rs_b == '0) hazard_b = 1'b0;
`endif
  end

  // Count of valid in-flight entries.
  always_comb begin
    pending_cnt = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pending_cnt = pending_cnt + CW'(v_q[k]);
    end
  end

endmodule
